rle_symbol_serializer: RTL

Sits directly downstream of the root `module_64bit` run-length merge node in the entropy-coding path. Each cycle it accepts at most one merged 8x8 block descriptor (leading zeros, trailing zeros, nonzero flag, up to 64 packed `{run, value}` entries) through a valid/ready handshake. It then streams the block as one `(run, value, category)` symbol per accepted output beat for the Huffman encoder, inserting ZRL and EOB symbols per JPEG AC rules.

---
 rtl/rle_symbol_serializer_if.sv | 45 ++++
 rtl/rle_symbol_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rle_symbol_serializer_if.sv
// ---------------------------------------------------------------------------
// rle_symbol_serializer_if
//
// Bundles the descriptor input handshake and the symbol output handshake of
// rle_symbol_serializer.
//   in_valid / in_ready      : descriptor handshake (upstream run-length merge)
//   in_left, in_right        : zeros before first / after last nonzero coeff
//   in_flag                  : block has at least one nonzero entry
//   in_array, in_size        : packed {run[13:8], value[7:0]} entries, count
//   out_valid / out_ready    : symbol handshake (Huffman encoder)
//   out_run, out_value       : zero run and two's-complement coefficient
//   out_cat                  : magnitude category 0..8
//   out_eob, out_last        : end-of-block symbol, final symbol of block
// Modports: slave = serializer side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface rle_symbol_serializer_if #(
    parameter int ENTRY_W     = 14,
    parameter int MAX_ENTRIES = 64
);
    logic                           in_valid;
    logic                           in_ready;
    logic [5:0]                     in_left;
    logic [5:0]                     in_right;
    logic                           in_flag;
    logic [MAX_ENTRIES*ENTRY_W-1:0] in_array;
    logic [5:0]                     in_size;

    logic                           out_valid;
    logic                           out_ready;
    logic [5:0]                     out_run;
    logic [7:0]                     out_value;
    logic [3:0]                     out_cat;
    logic                           out_eob;
    logic                           out_last;

    modport slave (
        input  in_valid, in_left, in_right, in_flag, in_array, in_size, out_ready,
        output in_ready, out_valid, out_run, out_value, out_cat, out_eob, out_last
    );

    modport master (
        output in_valid, in_left, in_right, in_flag, in_array, in_size, out_ready,
        input  in_ready, out_valid, out_run, out_value, out_cat, out_eob, out_last
    );
endinterface

// File: rtl/rle_symbol_serializer.sv
// ---------------------------------------------------------------------------
// rle_symbol_serializer
//
// Accepts one merged 8x8 run-length block descriptor at a time and streams it
// as (run, value, category) symbols, one per accepted output beat, closing the
// block with an EOB symbol when trailing zeros remain.
//
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-high reset, aborts any block in flight
//   bus  : rle_symbol_serializer_if.slave (descriptor in, symbol out)
//
// Build option:
//   RLE_SER_ZRL_EN : when defined, runs above 15 are split into ZRL (15,0)
//                    symbols so out_run never exceeds 15. When undefined the
//                    ZRL state does not exist and the full 6-bit run is sent.
//
// All out_* signals come straight from flops. Each cycle the flops are loaded
// with the decode of the *next* state, so a stalled beat reloads identical
// values and stays stable while out_valid && !out_ready.
// ---------------------------------------------------------------------------
module rle_symbol_serializer #(
    parameter int ENTRY_W     = 14,
    parameter int MAX_ENTRIES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    rle_symbol_serializer_if.slave bus
);
    localparam int RUN_W = ENTRY_W - 8;
    localparam int IDX_W = $clog2(MAX_ENTRIES);
`ifdef RLE_SER_ZRL_EN
    // one extra bit so left + run (up to 126) can be compared against 15
    localparam int PEND_W = RUN_W + 1;
`else
    localparam int PEND_W = RUN_W;
`endif

    typedef logic [MAX_ENTRIES-1:0][ENTRY_W-1:0] arr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        EOB  = 2'd2
`ifdef RLE_SER_ZRL_EN
        , ZRL = 2'd3
`endif
    } state_t;

    state_t              state_q, state_nx;
    logic [IDX_W-1:0]    idx_q, idx_nx;
    logic [PEND_W-1:0]   pend_q, pend_nx;
    logic [5:0]          right_q, right_nx;
    arr_t                arr_q, arr_sel;
    logic                armed_q;
    logic                in_ready;
    logic                accept;
    logic                hs;

    logic                valid_q, valid_nx;
    logic [RUN_W-1:0]    run_q, run_nx;
    logic [7:0]          value_q, value_nx;
    logic [3:0]          cat_q, cat_nx;
    logic                eob_q, eob_nx;
    logic                last_q, last_nx;

    // Bits needed for |v|; -128 has magnitude 128 and lands in category 8.
    function automatic logic [3:0] cat_of(input logic [7:0] v);
        logic [7:0] mag;
        logic [3:0] c;
        mag = v[7] ? 8'(~v + 8'd1) : v;
        c   = 4'd0;
        for (int b = 0; b < 8; b++) begin
            if (mag[b]) c = 4'(b + 1);
        end
        return c;
    endfunction

    // armed_q keeps in_ready low during reset and until the first edge after it.
    assign in_ready = (state_q == IDLE) && armed_q;
    assign accept   = bus.in_valid && in_ready;
    assign hs       = valid_q && bus.out_ready;

    // Next-state and next-datapath
    always_comb begin
        state_nx = state_q;
        idx_nx   = idx_q;
        pend_nx  = pend_q;
        right_nx = right_q;
        arr_sel  = arr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    arr_sel  = bus.in_array;
                    right_nx = bus.in_right;
                    // size 0 wraps to the top slot, i.e. a full 64-entry block
                    idx_nx   = IDX_W'(bus.in_size - 6'd1);
                    pend_nx  = PEND_W'(bus.in_left)
                             + PEND_W'(arr_sel[idx_nx][ENTRY_W-1:8]);
                    state_nx = bus.in_flag ? EMIT : EOB;
                end
            end
            EMIT: begin
                if (hs) begin
                    if (idx_q == '0) begin
                        state_nx = (right_q != '0) ? EOB : IDLE;
                    end else begin
                        idx_nx   = idx_q - IDX_W'(1);
                        pend_nx  = PEND_W'(arr_q[idx_nx][ENTRY_W-1:8]);
                        state_nx = EMIT;
                    end
                end
            end
`ifdef RLE_SER_ZRL_EN
            ZRL: begin
                if (hs) begin
                    pend_nx  = pend_q - PEND_W'(16);
                    state_nx = EMIT;
                end
            end
`endif
            EOB: begin
                if (hs) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
`ifdef RLE_SER_ZRL_EN
        // Any coefficient whose pending run is too long goes through ZRL first;
        // a stalled EMIT never trips this since it was entered with run <= 15.
        if (state_nx == EMIT && pend_nx > PEND_W'(15)) state_nx = ZRL;
`endif
    end

    // Output decode of the next state, registered below
    always_comb begin
        valid_nx = 1'b0;
        run_nx   = '0;
        value_nx = '0;
        cat_nx   = '0;
        eob_nx   = 1'b0;
        last_nx  = 1'b0;
        case (state_nx)
            EMIT: begin
                valid_nx = 1'b1;
                run_nx   = RUN_W'(pend_nx);
                value_nx = arr_sel[idx_nx][7:0];
                cat_nx   = cat_of(arr_sel[idx_nx][7:0]);
                last_nx  = (idx_nx == '0) && (right_nx == '0);
            end
`ifdef RLE_SER_ZRL_EN
            ZRL: begin
                valid_nx = 1'b1;
                run_nx   = RUN_W'(15);
            end
`endif
            EOB: begin
                valid_nx = 1'b1;
                eob_nx   = 1'b1;
                last_nx  = 1'b1;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    // Control datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
            idx_q   <= '0;
            pend_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
            run_q   <= '0;
            value_q <= '0;
            cat_q   <= '0;
            eob_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            idx_q   <= idx_nx;
            pend_q  <= pend_nx;
            right_q <= right_nx;
            valid_q <= valid_nx;
            run_q   <= run_nx;
            value_q <= value_nx;
            cat_q   <= cat_nx;
            eob_q   <= eob_nx;
            last_q  <= last_nx;
        end
    end

    // Entry storage needs no reset: it is only read after a fresh accept.
    always_ff @(posedge clk) begin
        if (accept) arr_q <= arr_sel;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_run   = run_q;
    assign bus.out_value = value_q;
    assign bus.out_cat   = cat_q;
    assign bus.out_eob   = eob_q;
    assign bus.out_last  = last_q;
endmodule
